// File: rtl/alu_writeback_stage.sv
// Writeback stage behind the 9-bit ALU: commits results and flags, pulses branches,
// and runs LW/SW through a req/ack data-memory port with a timeout abort.
module alu_writeback_stage #(
    parameter int reg_width   = 9,
    parameter int op_width    = 3,
    parameter int addr_width  = 3,
    parameter int mem_timeout = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [op_width-1:0]   in_op,
    input  logic [reg_width-1:0]  in_res,
    input  logic [reg_width-1:0]  in_car,
    input  logic                  in_zero,
    input  logic                  in_jump,
    input  logic [addr_width-1:0] in_rd,
    input  logic                  in_load,
    input  logic [reg_width-1:0]  in_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [reg_width-1:0]  mem_addr,
    output logic [reg_width-1:0]  mem_wdata,
    input  logic                  mem_ack,
    input  logic [reg_width-1:0]  mem_rdata,
    output logic                  wb_en,
    output logic [addr_width-1:0] wb_addr,
    output logic [reg_width-1:0]  wb_data,
    output logic [reg_width-1:0]  flag_car,
    output logic                  flag_zero,
    output logic                  br_taken,
    output logic                  mem_err,
    output logic [15:0]           retire_cnt
);

    localparam logic [op_width-1:0] OP_CAR = op_width'(2);
    localparam logic [op_width-1:0] OP_BR  = op_width'(5);
    localparam logic [op_width-1:0] OP_MEM = op_width'(6);
    localparam logic [7:0]          TMO_LAST = 8'(mem_timeout - 1);

    // Handshake: a transfer moves on a rising edge where in_valid && in_ready;
    // the memory side completes on a rising edge where mem_req && mem_ack.
    typedef enum logic {IDLE, MEM} state_t;
    state_t state, state_nxt;

    logic [7:0]            tmo_cnt;
    logic                  pend_load;
    logic [addr_width-1:0] pend_rd;
    logic                  accept;
    logic                  ack;
    logic                  timeout;

    // Gated by rst_n so in_ready also reads 0 while reset is held.
    assign in_ready = rst_n && (state == IDLE);
    assign mem_req  = (state == MEM);
    assign accept   = in_valid && in_ready;
    assign ack      = (state == MEM) && mem_ack;
    assign timeout  = (state == MEM) && !mem_ack && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && in_op == OP_MEM) state_nxt = MEM;
            MEM:  if (ack || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            flag_car   <= '0;
            flag_zero  <= 1'b0;
            br_taken   <= 1'b0;
            mem_err    <= 1'b0;
            retire_cnt <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            tmo_cnt    <= '0;
            pend_load  <= 1'b0;
            pend_rd    <= '0;
        end else begin
            wb_en    <= 1'b0;
            br_taken <= 1'b0;
            if (accept) begin
                if (in_op != OP_MEM) retire_cnt <= retire_cnt + 16'd1;
                if (in_op < OP_BR) begin
                    flag_zero <= in_zero;
                    if (in_op >= OP_CAR) flag_car <= in_car;
                    // Register 0 is never written, and wb_addr/wb_data keep their old value.
                    if (in_rd != '0) begin
                        wb_en   <= 1'b1;
                        wb_addr <= in_rd;
                        wb_data <= in_res;
                    end
                end
                if (in_op == OP_BR) br_taken <= in_jump;
                if (in_op == OP_MEM) begin
                    mem_addr  <= in_res;
                    mem_we    <= ~in_load;
                    mem_wdata <= in_wdata;
                    pend_load <= in_load;
                    pend_rd   <= in_rd;
                    tmo_cnt   <= '0;
                end
            end else if (ack) begin
                retire_cnt <= retire_cnt + 16'd1;
                tmo_cnt    <= '0;
                if (pend_load && pend_rd != '0) begin
                    wb_en   <= 1'b1;
                    wb_addr <= pend_rd;
                    wb_data <= mem_rdata;
                end
            end else if (timeout) begin
                mem_err <= 1'b1;
                tmo_cnt <= '0;
            end else if (state == MEM) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage: stimulus pushes expected wb/branch events,
// a negedge monitor pops and compares them; state-style outputs are checked inline.
module tb_alu_writeback_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = '0;
    logic [8:0] in_res = '0;
    logic [8:0] in_car = '0;
    logic       in_zero = 1'b0;
    logic       in_jump = 1'b0;
    logic [2:0] in_rd = '0;
    logic       in_load = 1'b0;
    logic [8:0] in_wdata = '0;
    logic       mem_req;
    logic       mem_we;
    logic [8:0] mem_addr;
    logic [8:0] mem_wdata;
    logic       mem_ack = 1'b0;
    logic [8:0] mem_rdata = '0;
    logic       wb_en;
    logic [2:0] wb_addr;
    logic [8:0] wb_data;
    logic [8:0] flag_car;
    logic       flag_zero;
    logic       br_taken;
    logic       mem_err;
    logic [15:0] retire_cnt;

    int tests = 0;
    int fails = 0;
    // Event record: {kind[1:0] = {br, wb}, addr[2:0], data[8:0]}
    logic [13:0] exp_q[$];

    alu_writeback_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_res(in_res), .in_car(in_car), .in_zero(in_zero),
        .in_jump(in_jump), .in_rd(in_rd), .in_load(in_load), .in_wdata(in_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flag_car(flag_car), .flag_zero(flag_zero),
        .br_taken(br_taken), .mem_err(mem_err), .retire_cnt(retire_cnt)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_wb(input logic [2:0] a, input logic [8:0] d);
        exp_q.push_back({2'b01, a, d});
    endtask

    task automatic push_br();
        exp_q.push_back({2'b10, 3'd0, 9'd0});
    endtask

    // Driver: called at a negedge, returns at the negedge after the accept edge.
    task automatic send(input logic [2:0] op, input logic [8:0] res, input logic [8:0] car,
                        input logic zero, input logic jump, input logic [2:0] rd,
                        input logic load, input logic [8:0] wdata);
        in_valid = 1'b1;
        in_op    = op;
        in_res   = res;
        in_car   = car;
        in_zero  = zero;
        in_jump  = jump;
        in_rd    = rd;
        in_load  = load;
        in_wdata = wdata;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: every wb/branch pulse must match the head of the expected queue.
    initial begin
        logic [13:0] act;
        logic [13:0] exp;
        forever begin
            @(negedge clk);
            if (wb_en || br_taken) begin
                act = wb_en ? {br_taken, wb_en, wb_addr, wb_data} : {br_taken, wb_en, 3'd0, 9'd0};
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(act), 32'h0);
                end else begin
                    exp = exp_q.pop_front();
                    check("event", 32'(act), 32'(exp));
                end
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_retire", 32'(retire_cnt), 32'h0);
        check("rst_flags", 32'({flag_car, flag_zero, mem_err}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'h1);

        // Op 2 writes back and updates carry.
        push_wb(3'd3, 9'h1F0);
        send(3'd2, 9'h1F0, 9'h001, 1'b0, 1'b0, 3'd3, 1'b0, 9'h0);
        check("op2_flag_car", 32'(flag_car), 32'h001);
        check("op2_flag_zero", 32'(flag_zero), 32'h0);
        check("op2_retire", 32'(retire_cnt), 32'd1);

        // Op 0 to r0: no writeback, zero flag set, carry kept.
        send(3'd0, 9'h000, 9'h1FF, 1'b1, 1'b0, 3'd0, 1'b0, 9'h0);
        check("op0_flag_zero", 32'(flag_zero), 32'h1);
        check("op0_flag_car", 32'(flag_car), 32'h001);
        check("op0_retire", 32'(retire_cnt), 32'd2);
        check("op0_wb_en", 32'(wb_en), 32'h0);

        // Branch taken then not taken, back to back.
        push_br();
        send(3'd5, 9'h000, 9'h000, 1'b0, 1'b1, 3'd1, 1'b0, 9'h0);
        send(3'd5, 9'h000, 9'h000, 1'b0, 1'b0, 3'd1, 1'b0, 9'h0);
        check("br_second", 32'(br_taken), 32'h0);
        check("br_retire", 32'(retire_cnt), 32'd4);

        // Same destination back to back; op 1 keeps carry, op 3 updates it; op 7 only retires.
        push_wb(3'd2, 9'h055);
        push_wb(3'd2, 9'h0AA);
        send(3'd1, 9'h055, 9'h100, 1'b0, 1'b0, 3'd2, 1'b0, 9'h0);
        check("op1_flag_car", 32'(flag_car), 32'h001);
        send(3'd3, 9'h0AA, 9'h1FF, 1'b0, 1'b0, 3'd2, 1'b0, 9'h0);
        check("op3_flag_car", 32'(flag_car), 32'h1FF);
        send(3'd7, 9'h123, 9'h000, 1'b1, 1'b1, 3'd4, 1'b0, 9'h0);
        check("op7_retire", 32'(retire_cnt), 32'd7);
        check("op7_flag_zero", 32'(flag_zero), 32'h0);
        check("op7_hold_wb_data", 32'(wb_data), 32'h0AA);

        // LW acked on the third request cycle.
        push_wb(3'd5, 9'h0AB);
        send(3'd6, 9'h040, 9'h000, 1'b1, 1'b0, 3'd5, 1'b1, 9'h0);
        for (int i = 0; i < 3; i++) begin
            check("lw_req", 32'({mem_req, in_ready, mem_we}), 32'b100);
            check("lw_addr", 32'(mem_addr), 32'h040);
            if (i == 2) begin
                mem_ack   = 1'b1;
                mem_rdata = 9'h0AB;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check("lw_done", 32'({mem_req, in_ready}), 32'b01);
        check("lw_retire", 32'(retire_cnt), 32'd8);
        check("lw_flags", 32'({flag_car, flag_zero}), 32'({9'h1FF, 1'b0}));

        // SW acked in its first request cycle: no writeback.
        send(3'd6, 9'h010, 9'h000, 1'b0, 1'b0, 3'd4, 1'b0, 9'h0FF);
        check("sw_req", 32'({mem_req, mem_we}), 32'b11);
        check("sw_wdata", 32'(mem_wdata), 32'h0FF);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("sw_done", 32'({mem_req, in_ready}), 32'b01);
        check("sw_retire", 32'(retire_cnt), 32'd9);

        // SW never acked: abort after 15 request cycles.
        send(3'd6, 9'h077, 9'h000, 1'b0, 1'b0, 3'd1, 1'b0, 9'h123);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("tmo_cycles", 32'(n), 32'd15);
        check("tmo_err", 32'(mem_err), 32'h1);
        check("tmo_ready", 32'(in_ready), 32'h1);
        check("tmo_retire", 32'(retire_cnt), 32'd9);
        repeat (3) @(negedge clk);
        check("tmo_err_sticky", 32'(mem_err), 32'h1);

        // Reset in the middle of a LW, then a stray ack.
        send(3'd6, 9'h033, 9'h000, 1'b0, 1'b0, 3'd6, 1'b1, 9'h0);
        check("rmem_req", 32'(mem_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rmem_req_drop", 32'(mem_req), 32'h0);
        check("rmem_outs", 32'({wb_en, br_taken, mem_err, flag_zero, mem_we}), 32'h0);
        check("rmem_regs", 32'({retire_cnt, mem_addr}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 9'h1EE;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        check("rmem_ignore_ack", 32'({mem_req, wb_en, in_ready}), 32'b001);
        check("rmem_retire", 32'(retire_cnt), 32'd0);

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Stage directly downstream of the 9-bit ALU. Captures one ALU result per accepted transfer.
- Commits ALU results to the register-file write port and updates the architectural carry/zero flag registers.
- Turns BEQ jump into a one-cycle branch pulse.
- Sequences LW/SW (ALU op 6) through a request/acknowledge data-memory port, with a timeout and a retired-instruction counter.

Parameters:
- reg_width, 9, datapath width; matches ALU res/car width
- op_width, 3, ALU opcode width
- addr_width, 3, register-file index width
- mem_timeout, 15, max cycles waiting for mem_ack before abort (1..255)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept
- in_op  in  op_width  ALU opcode of this result
- in_res  in  reg_width  ALU res_out
- in_car  in  reg_width  ALU car_out
- in_zero  in  1  ALU zero
- in_jump  in  1  ALU jump
- in_rd  in  addr_width  destination register
- in_load  in  1  op 6 only: 1 = LW, 0 = SW
- in_wdata  in  reg_width  SW store data
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  reg_width  memory address
- mem_wdata  out  reg_width  write data
- mem_ack  in  1  memory done; sampled only while mem_req=1
- mem_rdata  in  reg_width  load data; valid with mem_ack
- wb_en  out  1  register-file write strobe (one-cycle pulse)
- wb_addr  out  addr_width  write index
- wb_data  out  reg_width  write data
- flag_car  out  reg_width  carry/shift-out flag register
- flag_zero  out  1  zero flag register
- br_taken  out  1  one-cycle branch pulse
- mem_err  out  1  sticky timeout error
- retire_cnt  out  16  retired-transfer counter; wraps

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state IDLE; timeout counter 0.
  - Reset mid-MEM drops mem_req immediately; nothing is written back.
- States:
  - IDLE: in_ready=1.
  - MEM: in_ready=0.
  - Transfer accepted on an edge where in_valid & in_ready.
- Accept in IDLE, by op:
  - Ops 0,1: next cycle wb_en=1, wb_data=in_res, wb_addr=in_rd; flag_zero<=in_zero; flag_car unchanged.
  - Ops 2,3,4: as ops 0,1, and flag_car<=in_car.
  - Op 5: no writeback, flags unchanged; br_taken=in_jump for the next cycle only.
  - Op 6: go to MEM. From the next cycle: mem_req=1, mem_addr=in_res, mem_we=~in_load, mem_wdata=in_wdata.
  - Op 7: no-op; consumed and retired.
- wb_en gating: wb_en is never asserted for in_rd==0; the transfer still retires.
- Output timing:
  - wb_en and br_taken are registered one-cycle pulses.
  - wb_addr/wb_data hold their last value when wb_en=0.
- MEM state:
  - mem_req, mem_we, mem_addr and mem_wdata stay constant until the ack edge.
  - Timeout counter increments each MEM cycle without ack.
- mem_ack=1 at an edge:
  - mem_req drops; return to IDLE; ready again the next cycle.
  - LW: wb_en pulse next cycle with wb_data=mem_rdata captured at the ack edge.
  - SW: no writeback.
- Timeout (counter reaches mem_timeout with no ack):
  - mem_req drops; mem_err<=1; return to IDLE.
  - No writeback and no retire.
  - mem_err is cleared only by reset.
- Memory flags: memory ops leave flag_car and flag_zero unchanged.
- retire_cnt: +1 on each retired transfer (ALU ops at accept, memory ops at ack); 16'hFFFF wraps to 0.
- Throughput and latency:
  - ALU/branch ops: one per cycle back to back; latency 1 cycle from accept to wb_en.
  - Memory ops: minimum 2 cycles (ack in the first req cycle).
- Back-to-back ALU accepts where the second targets the same in_rd: two consecutive wb_en pulses in order.

Test Plan:
- Reset then op 2, in_res=9'h1F0, in_car=9'h001, in_zero=0, in_rd=3 -> next cycle wb_en=1, wb_addr=3, wb_data=9'h1F0, flag_car=9'h001, retire_cnt=1.
- Op 0 with in_res=0, in_zero=1, in_rd=0 -> wb_en stays 0, flag_zero=1, flag_car unchanged, retire_cnt increments.
- Op 5, in_jump=1, then op 5, in_jump=0 on consecutive cycles -> br_taken is 1 for exactly one cycle, then 0; no wb_en.
- LW: op 6, in_load=1, in_res=9'h040, in_rd=5; memory acks 3 cycles later with mem_rdata=9'h0AB -> mem_req high 3 cycles with mem_addr=9'h040, mem_we=0; in_ready=0 throughout; wb_en pulse with wb_data=9'h0AB, wb_addr=5.
- SW with mem_ack never asserted, mem_timeout=15 -> mem_req drops after 15 cycles, mem_err=1 and stays 1, no wb_en, retire_cnt unchanged, in_ready=1 again.
- rst_n pulsed low during MEM -> mem_req=0 asynchronously; all outputs 0; a later mem_ack is ignored.
